// File: rtl/data_mem_system.sv
// Data-memory subsystem for the single-cycle ARM core: RAM, I/O window and cycle counter
// behind a req/ready handshake with a fixed number of wait states.
module data_mem_system #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 256,
    parameter int WAIT = 2,
    parameter int N_IO = 4,
    parameter logic [ADDR_W-1:0] IO_BASE = 'h0000_1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        adr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      be,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ready,
    output logic                     err,
    output logic [N_IO*DATA_W-1:0]   io_out,
    input  logic [DATA_W-1:0]        io_in,
    output logic [1:0]               state_dbg
);
    localparam int NB = DATA_W / 8;
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT_ST = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT);
    localparam logic [ADDR_W-1:0] RAM_TOP = ADDR_W'(DEPTH * 4);
    localparam logic [ADDR_W-1:0] IO_TOP = IO_BASE + ADDR_W'(4 * (N_IO + 2));

    // Handshake: req is sampled only in IDLE and must stay high until ready;
    // ready is a one-cycle pulse, and rdata/err are meaningful only while it is high.
    logic [1:0]          state;
    logic [3:0]          wcnt;
    logic [ADDR_W-1:0]   lat_adr;
    logic                lat_we;
    logic [DATA_W-1:0]   lat_wdata;
    logic [NB-1:0]       lat_be;
    logic [31:0]         cycle_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   io_reg [N_IO];

    logic [ADDR_W-1:0]   cur_adr;
    logic                cur_we;
    logic [ADDR_W-1:0]   io_off;
    logic                misaligned, ram_hit, io_hit, wr_commit;
    logic [IW-1:0]       ram_idx;
    logic [DATA_W-1:0]   rd_word;
    logic                acc_err;

    // With WAIT=0 the decode happens on the accepting edge, before the latches hold the request.
    assign cur_adr    = (state == IDLE) ? adr : lat_adr;
    assign cur_we     = (state == IDLE) ? we : lat_we;
    assign io_off     = (cur_adr - IO_BASE) >> 2;
    assign misaligned = |cur_adr[1:0];
    assign ram_hit    = !misaligned && (cur_adr < RAM_TOP);
    assign io_hit     = !misaligned && (cur_adr >= IO_BASE) && (cur_adr < IO_TOP);
    assign ram_idx    = cur_adr[IW+1:2];
    assign wr_commit  = (state == DONE) && lat_we;
    assign ready      = (state == DONE);
    assign state_dbg  = state;

    always_comb begin
        rd_word = '0;
        acc_err = 1'b0;
        if (ram_hit) begin
            rd_word = mem[ram_idx];
        end else if (io_hit) begin
            if (io_off == ADDR_W'(N_IO)) rd_word = io_in;
            else if (io_off == ADDR_W'(N_IO + 1)) rd_word = DATA_W'(cycle_cnt);
            for (int k = 0; k < N_IO; k++) begin
                if (io_off == ADDR_W'(k)) rd_word = io_reg[k];
            end
        end else begin
            acc_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            lat_adr   <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            rdata <= '0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_adr   <= adr;
                        lat_we    <= we;
                        lat_wdata <= wdata;
                        lat_be    <= be;
                        wcnt      <= WAIT_INIT;
                        if (WAIT_INIT == 4'd0) begin
                            state <= DONE;
                            rdata <= cur_we ? '0 : rd_word;
                            err   <= acc_err;
                        end else begin
                            state <= WAIT_ST;
                        end
                    end
                end
                WAIT_ST: begin
                    if (wcnt == 4'd1) begin
                        state <= DONE;
                        rdata <= cur_we ? '0 : rd_word;
                        err   <= acc_err;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_commit && ram_hit) begin
            for (int i = 0; i < NB; i++) begin
                if (lat_be[i]) mem[ram_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_IO; k++) io_reg[k] <= '0;
        end else if (wr_commit && io_hit) begin
            for (int k = 0; k < N_IO; k++) begin
                for (int i = 0; i < NB; i++) begin
                    if (io_off == ADDR_W'(k) && lat_be[i]) io_reg[k][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 32'd1;
    end

    always_comb begin
        io_out = '0;
        for (int k = 0; k < N_IO; k++) io_out[k*DATA_W +: DATA_W] = io_reg[k];
    end
endmodule

// File: tb/tb_data_mem_system.sv
// Bench for data_mem_system: a WAIT=2 instance and a WAIT=0 instance share clock,
// reset and data-side inputs; each has its own req line.
module tb_data_mem_system;
    localparam logic [31:0] IO_BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        we = 1'b0;
    logic [31:0] adr = '0, wdata = '0, io_in = '0;
    logic [3:0]  be = '0;
    logic        req2 = 1'b0, req0 = 1'b0;
    logic [31:0] rdata2, rdata0;
    logic        ready2, ready0, err2, err0;
    logic [127:0] io_out2, io_out0;
    logic [1:0]  st2, st0;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] ram_m [8];

    data_mem_system #(.WAIT(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we), .adr(adr), .wdata(wdata), .be(be),
        .rdata(rdata2), .ready(ready2), .err(err2), .io_out(io_out2), .io_in(io_in),
        .state_dbg(st2));

    data_mem_system #(.WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .adr(adr), .wdata(wdata), .be(be),
        .rdata(rdata0), .ready(ready0), .err(err0), .io_out(io_out0), .io_in(io_in),
        .state_dbg(st0));

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    // One complete transaction; expected {err, rdata} goes into the scoreboard when driven.
    task automatic access(input bit fast, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic [32:0] exp, input string name);
        int n;
        int lat;
        logic rdy;
        logic [32:0] got, e;
        lat = fast ? 1 : 3;
        exp_q.push_back(exp);
        @(negedge clk);
        we = w; adr = a; wdata = d; be = b;
        if (fast) req0 = 1'b1; else req2 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            rdy = fast ? ready0 : ready2;
        end while (!rdy && n < 40);
        req0 = 1'b0; req2 = 1'b0;
        checks++;
        if (!rdy || n != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (ready=%0b), want %0d", name, n, rdy, lat);
        end
        got = fast ? {err0, (w ? 32'h0 : rdata0)} : {err2, (w ? 32'h0 : rdata2)};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s data: got err=%0b rdata=%h, want err=%0b rdata=%h",
                     name, got[32], got[31:0], e[32], e[31:0]);
        end
        @(posedge clk); #1;
        checks++;
        if ((fast ? {ready0, rdata0} : {ready2, rdata2}) !== 33'h0) begin
            errors++;
            $display("FAIL %s pulse_end: ready/rdata still active after one cycle", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready2, err2, rdata2, st2} !== 36'h0 || {ready0, err0, rdata0, st0} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%0b err=%0b rdata=%h st=%0d, want all 0",
                     ready2, err2, rdata2, st2);
        end
        checks++;
        if (io_out2 !== 128'h0 || io_out0 !== 128'h0) begin
            errors++;
            $display("FAIL reset_io_out: got %h, want 0", io_out2);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, {1'b0, 32'h0}, "wr_0x10");
        access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, {1'b0, 32'hDEAD_BEEF}, "rd_0x10");
        access(1'b0, 1'b1, 32'h0, 32'h0123_4567, 4'hF, {1'b0, 32'h0}, "wr_0x0");
    endtask

    task automatic test_byte_lanes();
        access(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, {1'b0, 32'h0}, "wr_0x20_full");
        access(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, {1'b0, 32'h0}, "wr_0x20_lanes");
        access(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, {1'b0, 32'h11BB_33DD}, "rd_0x20_lanes");
        access(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, {1'b0, 32'h0}, "wr_0x20_be0");
        access(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, {1'b0, 32'h11BB_33DD}, "rd_0x20_be0");
    endtask

    task automatic test_io();
        access(1'b0, 1'b1, IO_BASE + 32'd4, 32'h5A, 4'hF, {1'b0, 32'h0}, "wr_io1");
        checks++;
        if (io_out2 !== {32'h0, 32'h0, 32'h5A, 32'h0}) begin
            errors++;
            $display("FAIL io_out_after_wr: got %h, want reg1=5a others 0", io_out2);
        end
        io_in = 32'h0000_CAFE;
        access(1'b0, 1'b0, IO_BASE + 32'd16, 32'h0, 4'h0, {1'b0, 32'h0000_CAFE}, "rd_io_in");
        access(1'b0, 1'b1, IO_BASE + 32'd16, 32'h1234_5678, 4'hF, {1'b0, 32'h0}, "wr_io_in_ro");
        checks++;
        if (io_out2 !== {32'h0, 32'h0, 32'h5A, 32'h0}) begin
            errors++;
            $display("FAIL io_out_after_ro_wr: got %h, want reg1=5a others 0", io_out2);
        end
        access(1'b0, 1'b0, IO_BASE + 32'd4, 32'h0, 4'h0, {1'b0, 32'h5A}, "rd_io1");
    endtask

    task automatic test_faults();
        access(1'b0, 1'b0, 32'h3, 32'h0, 4'h0, {1'b1, 32'h0}, "rd_misaligned");
        access(1'b0, 1'b1, 32'h0000_8000, 32'hFFFF_FFFF, 4'hF, {1'b1, 32'h0}, "wr_unmapped");
        checks++;
        if (io_out2 !== {32'h0, 32'h0, 32'h5A, 32'h0}) begin
            errors++;
            $display("FAIL io_out_after_unmapped: got %h, want reg1=5a others 0", io_out2);
        end
        access(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, {1'b0, 32'h0123_4567}, "rd_0x0_intact");
        access(1'b0, 1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, {1'b1, 32'h0}, "wr_misaligned");
        access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, {1'b0, 32'hDEAD_BEEF}, "rd_0x10_intact");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        we = 1'b1; adr = 32'h10; wdata = 32'h5555_5555; be = 4'hF; req2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (io_out2 !== 128'h0 || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: got io_out=%h ready=%0b, want 0/0", io_out2, ready2);
        end
        access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, {1'b0, 32'hDEAD_BEEF}, "rd_after_abort");
    endtask

    task automatic test_back_to_back(input bit fast);
        int n;
        logic rdy;
        logic [31:0] c1, c2;
        @(negedge clk);
        we = 1'b0; adr = IO_BASE + 32'd20; be = 4'h0;
        if (fast) req0 = 1'b1; else req2 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            rdy = fast ? ready0 : ready2;
        end while (!rdy && n < 40);
        c1 = fast ? rdata0 : rdata2;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            rdy = fast ? ready0 : ready2;
        end while (!rdy && n < 40);
        c2 = fast ? rdata0 : rdata2;
        req0 = 1'b0; req2 = 1'b0;
        checks++;
        if (!rdy || n != (fast ? 2 : 4)) begin
            errors++;
            $display("FAIL b2b_spacing fast=%0b: got %0d cycles, want %0d", fast, n, fast ? 2 : 4);
        end
        checks++;
        if (c2 - c1 !== (fast ? 32'd2 : 32'd4)) begin
            errors++;
            $display("FAIL b2b_counter fast=%0b: got diff %0d, want %0d", fast, c2 - c1,
                     fast ? 2 : 4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wait0_random();
        logic [31:0] d;
        logic [3:0]  b;
        access(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, {1'b0, 32'h0}, "w0_wr_0x40");
        access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, {1'b0, 32'hCAFE_F00D}, "w0_rd_0x40");
        access(1'b1, 1'b0, 32'h7, 32'h0, 4'h0, {1'b1, 32'h0}, "w0_rd_misaligned");
        for (int i = 0; i < 8; i++) begin
            d = $urandom();
            ram_m[i] = d;
            access(1'b1, 1'b1, 32'h100 + 32'(4 * i), d, 4'hF, {1'b0, 32'h0}, "w0_rnd_init");
        end
        for (int i = 0; i < 8; i++) begin
            d = $urandom();
            b = 4'($urandom_range(0, 15));
            ram_m[i] = merge(ram_m[i], d, b);
            access(1'b1, 1'b1, 32'h100 + 32'(4 * i), d, b, {1'b0, 32'h0}, "w0_rnd_lanes");
        end
        for (int i = 0; i < 8; i++) begin
            access(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, {1'b0, ram_m[i]}, "w0_rnd_rd");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_io();
        test_faults();
        test_reset_mid();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_wait0_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
